// File: rtl/fifo_burst_reader_if.sv
// FIFO read port and output stream bundle for fifo_burst_reader.
// master: the burst reader (drives the FIFO read request and the stream).
// slave:  the environment (FIFO read side plus the stream consumer).
// Stream handshake: a word transfers on every rising edge where
// m_valid && m_ready; once m_valid is high, m_valid and m_data hold
// until that transfer happens.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    input  fifo_underflow,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    output fifo_underflow,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO.
// Drains burst_len_i words into a valid/ready stream through a 2-entry
// skid buffer, so a read already issued always has a slot to land in.
// Optional feature macro: FIFO_BURST_UNDERFLOW_CHK_EN (sticky underflow
// error on err_o); when undefined err_o is tied low.
// state_o exposes the FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_burst_reader_if.master  bus,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] burst_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] words_left_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic pop;
  logic push;
  logic room;
  logic rd_en;

  // A word leaves on a handshake; a word arrives the cycle after a read.
  assign pop  = (occ_q != 2'd0) && bus.m_ready;
  assign push = inflight_q;
  // Issuing now is safe if next cycle's occupancy plus this read fits in 2.
  assign room = (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; DRAIN leaves as soon as the buffer empties with
  // nothing in flight, so done follows the final handshake by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (burst_len_i != '0) ? S_RUN : S_DONE;
      S_RUN:   if (rd_en && (words_left_q == LEN_WIDTH'(1))) state_d = S_DRAIN;
      S_DRAIN: if (occ_d == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: read request, busy and done.
  always_comb begin
    rd_en  = (state_q == S_RUN) && !bus.fifo_empty &&
             (words_left_q != '0) && room;
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  // Skid buffer and word counter next-state; head is always the oldest word.
  always_comb begin
    occ_d        = occ_q;
    head_d       = head_q;
    tail_d       = tail_q;
    words_left_d = words_left_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.fifo_data_out;
        else               tail_d = bus.fifo_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.fifo_data_out;
        end else begin
          head_d = tail_q;
          tail_d = bus.fifo_data_out;
        end
      end
      default: ;
    endcase
    if ((state_q == S_IDLE) && start_i) words_left_d = burst_len_i;
    else if (rd_en)                     words_left_d = words_left_q - LEN_WIDTH'(1);
  end

  // Datapath registers; reset drops any word already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      words_left_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= rd_en;
      head_q       <= head_d;
      tail_q       <= tail_d;
      words_left_q <= words_left_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = head_q;
  assign words_left_o   = words_left_q;
  assign state_o        = state_q;

`ifdef FIFO_BURST_UNDERFLOW_CHK_EN
  logic err_q;

  // Sticky error: FIFO reported underflow right after one of our reads.
  always_ff @(posedge clk) begin
    if (rst)                                    err_q <= 1'b0;
    else if (inflight_q && bus.fifo_underflow)  err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_underflow;
  assign unused_underflow = bus.fifo_underflow;
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, stream scoreboard, directed bursts.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 8;
`ifdef FIFO_BURST_UNDERFLOW_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [LW-1:0] burst_len_i;
  logic          busy_o;
  logic          done_o;
  logic [LW-1:0] words_left_o;
  logic          err_o;
  logic [1:0]    state_o;
  logic          m_ready_tb;
  logic          force_uf;
  logic          uf_q = 1'b0;

  fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .start_i      (start_i),
    .burst_len_i  (burst_len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .words_left_o (words_left_o),
    .err_o        (err_o),
    .state_o      (state_o)
  );

  assign bus.m_ready        = m_ready_tb;
  assign bus.fifo_underflow = uf_q | force_uf;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] exp_q[$];
  logic [LW-1:0] wl_log[$];
  logic [LW-1:0] wl_prev;
  bit            log_wl = 0;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            done_base = 0;
  int            rd_cnt = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, new words appear after the next edge.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (fifo_q.size() != 0) begin
        bus.fifo_data_out <= fifo_q.pop_front();
        uf_q <= 1'b0;
      end else begin
        uf_q <= 1'b1;
      end
    end else begin
      uf_q <= 1'b0;
    end
    while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: scoreboard on stream handshakes, event counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        check("word_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("m_data_order", bus.m_data, exp_q.pop_front());
      end
      if (bus.fifo_rd_en) rd_cnt++;
      if (done_o) done_cnt++;
      if (log_wl && (words_left_o != wl_prev)) begin
        wl_log.push_back(words_left_o);
        wl_prev = words_left_o;
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
    pend_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic start_burst(input logic [LW-1:0] n);
    @(posedge clk); #1;
    start_i     = 1'b1;
    burst_len_i = n;
    done_base   = done_cnt;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while ((done_cnt == done_base) && (k < bound)) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", (done_cnt != done_base), 1);
    @(negedge clk);
    check("busy_after_done", busy_o, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},      bus.fifo_rd_en, 0);
    check({tag, "_m_valid"},    bus.m_valid, 0);
    check({tag, "_m_data"},     bus.m_data, 0);
    check({tag, "_busy"},       busy_o, 0);
    check({tag, "_done"},       done_o, 0);
    check({tag, "_words_left"}, words_left_o, 0);
    check({tag, "_err"},        err_o, 0);
    check({tag, "_state"},      state_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; burst_len_i = '0; m_ready_tb = 1'b1; force_uf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 4-word burst at full rate
    for (int w = 1; w <= 4; w++) push_word(DW'(w), 1'b1);
    start_burst(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_rd_en",   bus.fifo_rd_en, (i < 4));
      check("t1_m_valid", bus.m_valid, (i >= 2 && i <= 5));
      check("t1_done",    done_o, (i == 6));
      check("t1_busy",    busy_o, (i <= 6));
      if (i >= 2 && i <= 5) check("t1_m_data", bus.m_data, i - 1);
    end
    check("t1_all_out", exp_q.size(), 0);

    // zero-length burst
    rd_cnt = 0;
    start_burst(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_done",    done_o, (i == 0));
      check("t2_busy",    busy_o, (i == 0));
      check("t2_m_valid", bus.m_valid, 0);
    end
    check("t2_no_reads", rd_cnt, 0);

    // backpressure: 8 queued, 6 read, consumer stalled 10 cycles
    for (int w = 0; w < 8; w++) push_word(DW'(16'h0a00 + w), (w < 6));
    m_ready_tb = 1'b0;
    rd_cnt = 0;
    start_burst(6);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("t3_stall_reads", rd_cnt, 2);
    check("t3_m_valid",     bus.m_valid, 1);
    check("t3_m_data_held", bus.m_data, 16'h0a00);
    @(posedge clk); #1 m_ready_tb = 1'b1;
    wait_done(40);
    check("t3_all_out",   exp_q.size(), 0);
    check("t3_fifo_left", fifo_q.size(), 2);
    fifo_q.delete();
    @(posedge clk); #1;

    // FIFO runs dry mid-burst
    push_word(16'h0b01, 1'b1);
    push_word(16'h0b02, 1'b1);
    @(posedge clk); #1;
    wl_log.delete();
    wl_prev = words_left_o;
    log_wl  = 1;
    start_burst(3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t4_rd_while_empty", (bus.fifo_rd_en && bus.fifo_empty), 0);
      if (i == 6) push_word(16'h0b03, 1'b1);
    end
    log_wl = 0;
    wait_done(20);
    check("t4_all_out", exp_q.size(), 0);
    check("t4_wl_steps", wl_log.size(), 4);
    for (int k = 0; k < 4; k++)
      check("t4_wl_value", (k < wl_log.size()) ? wl_log[k] : LW'(8'hff), 3 - k);

    // reset in the middle of a burst
    for (int w = 0; w < 4; w++) push_word(DW'(16'h0c00 + w), 1'b0);
    m_ready_tb = 1'b0;
    start_burst(4);
    for (int k = 0; (k < 10) && (words_left_o != LW'(2)); k++) @(negedge clk);
    check("t5_wl_two", words_left_o, 2);
    pulse_reset();
    @(negedge clk);
    check_reset_outputs("t5_rst");
    fifo_q.delete();
    exp_q.delete();
    m_ready_tb = 1'b1;
    push_word(16'h0d01, 1'b1);
    push_word(16'h0d02, 1'b1);
    start_burst(2);
    wait_done(20);
    check("t5_all_out", exp_q.size(), 0);

    // underflow reported after a read
    check("t6_err_before", err_o, 0);
    push_word(16'h0e01, 1'b1);
    @(posedge clk); #1 force_uf = 1'b1;
    start_burst(1);
    wait_done(20);
    @(posedge clk); #1 force_uf = 1'b0;
    @(negedge clk);
    check("t6_err_set", err_o, EXP_ERR);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", err_o, EXP_ERR);
    check("t6_all_out", exp_q.size(), 0);
    pulse_reset();
    @(negedge clk);
    check("t6_err_reset", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the synchronous FIFO. On a `start` command it drains exactly `burst_len` words from the FIFO read port and presents them on a valid/ready output stream, using an internal 2-entry skid buffer so that read requests are never lost to downstream backpressure. It sits between the FIFO and any stream consumer (DMA engine, serializer, packet builder) and reports burst completion with a single-cycle `done` pulse.

## Interface
- `DATA_WIDTH`, 16, FIFO word width; must match the FIFO.
- `LEN_WIDTH`, 8, width of the burst length and remaining-word counter.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `burst_len`  in  LEN_WIDTH  number of words to read; latched when `start` is accepted.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `fifo_data_out`  in  DATA_WIDTH  FIFO registered read data, valid the cycle after an accepted read.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  consumer accepts the word when `m_valid && m_ready`.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse when the last word of the burst has been accepted downstream.
- `words_left`  out  LEN_WIDTH  words not yet requested from the FIFO.
- `err`  out  1  sticky underflow error (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: when `start`=1, latch `burst_len` into `words_left` and set `busy`. If `burst_len`!=0, go to RUN. If `burst_len`=0, go to DONE with no reads.
- RUN: drive `fifo_rd_en`=1 in a cycle only when all three hold:
  - `!fifo_empty`
  - `words_left`!=0
  - `occ + inflight - (m_valid && m_ready) < 2`, where `occ` is the skid-buffer occupancy (0..2) and `inflight` is 1 if a read was issued in the previous cycle.
- `fifo_rd_en` is a combinational function of the current state and counters. Each issued read decrements `words_left` by 1. When `words_left` reaches 0, go to DRAIN.
- Data capture: a read issued in cycle t returns `fifo_data_out` in cycle t+1, which is written into the skid buffer at the end of t+1.
- The skid buffer is FIFO-ordered. `m_data` always shows the head entry, and `m_valid` = (`occ`!=0).
- DRAIN: no reads are issued. When `occ`=0 and `inflight`=0, go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0 from the next cycle, then go to IDLE.
- `start` is ignored while `busy`=1.
- Words are never dropped or duplicated. Output order equals FIFO read order.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `words_left`=0, `err`=0. FSM goes to IDLE and the skid buffer is emptied.
- Start latency: with `start` accepted at edge e0, the first `fifo_rd_en` can be high in the cycle after e0 (if the FIFO is non-empty).
- Read-to-output latency: 2 cycles from `fifo_rd_en` high to `m_valid` high for that word.
- Throughput: sustains 1 word/cycle while `m_ready`=1 and the FIFO is non-empty.
- Backpressure: with `m_ready`=0, at most 2 words are held (`occ` + `inflight` <= 2). `m_valid` and `m_data` stay stable until accepted.
- FIFO empty mid-burst: reads stall and the FSM stays in RUN; reading resumes the cycle `fifo_empty` drops.
- Done latency: `done` fires in the cycle after the final handshake.
- Reset mid-burst: everything is abandoned. A word already popped from the FIFO but not yet delivered is lost. This is accepted behaviour, and software must re-sync.

## Configuration
- `FIFO_BURST_UNDERFLOW_CHK_EN` defined:
  - `err` is set to 1 if `fifo_underflow`=1 in the cycle after this block drove `fifo_rd_en`=1.
  - `err` holds until `rst`. It does not stop the burst.
- `FIFO_BURST_UNDERFLOW_CHK_EN` undefined:
  - `err` is tied to 0 and `fifo_underflow` is ignored.

## Test plan
- FIFO preloaded with 0x0001..0x0004, `burst_len`=4, `m_ready`=1 -> `fifo_rd_en` high for 4 consecutive cycles. `m_data` is 0x0001..0x0004 on consecutive cycles starting 2 cycles after the first read, then one `done` pulse, then `busy`=0.
- `burst_len`=0 -> `done` 1 cycle after start, `fifo_rd_en` never asserted, `m_valid` stays 0.
- 8 words queued, `burst_len`=6, `m_ready`=0 for 10 cycles then 1 -> exactly 2 reads issued during the stall, `m_data` held at the first word. The 6 words are then delivered in order and the FIFO retains 2 words.
- FIFO empty after 2 words, 3rd word pushed 5 cycles later, `burst_len`=3 -> `fifo_rd_en`=0 while `fifo_empty`=1. All 3 words delivered, `words_left` goes 3,2,1,0.
- `rst` pulsed while `words_left`=2 -> all outputs at reset values the next cycle, and a new `start` works normally.
- With macro defined, force `fifo_underflow`=1 after a read -> `err`=1 until reset. With macro undefined, `err` stays 0.
